clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter N_CH, default 2: number of independent divider channels (1..8).
REQ-002 Parameter RATIO_WIDTH, default 4: width of each channel's divide ratio.
REQ-003 i_ref_clk  input  1: single reference clock; all state updates on its rising edge.
REQ-004 i_rst  input  1: synchronous, active-high reset, sampled on rising i_ref_clk.
REQ-005 i_clk_en  input  N_CH: per-channel enable, active-high; bit c controls channel c.
REQ-006 i_div_ratio  input  N_CH*RATIO_WIDTH: channel c's ratio is in bits [c*RATIO_WIDTH +: RATIO_WIDTH].
REQ-007 o_div_clk  output  N_CH: per-channel divided clock.
REQ-008 o_tick  output  N_CH: per-channel one-ref-cycle pulse marking each divided-clock period start (present only per REQ-024).

Function
REQ-009 Each channel SHALL hold an active ratio R_act (RATIO_WIDTH bits), counter cnt (RATIO_WIDTH bits) and registered output div_q.
REQ-010 A channel is in bypass when i_clk_en[c]=0 or R_act<=1; in bypass, o_div_clk[c] SHALL equal i_ref_clk combinationally, cnt=0, div_q=0.
REQ-011 In divide mode (i_clk_en[c]=1, R_act>=2), o_div_clk[c] SHALL equal div_q.
REQ-012 In divide mode, cnt SHALL count 0..R_act-1 and wrap to 0; div_q SHALL be 1 for cnt in [0, H-1] and 0 for cnt in [H, R_act-1], where H=ceil(R_act/2).
REQ-013 Even R_act: 50% duty; odd R_act: high H cycles, low H-1 cycles (e.g. R=5: 3 high, 2 low).
REQ-014 div_q SHALL be registered: it reflects the cnt value loaded on the same edge, with no combinational path from cnt.
REQ-015 R_act SHALL load from i_div_ratio slice only at a period boundary: on the edge where cnt wraps R_act-1->0, or on any edge while the channel is in bypass.
REQ-016 A ratio change mid-period SHALL NOT shorten or lengthen the current period; the new ratio takes effect at the next period start.
REQ-017 On leaving bypass (enable 0->1 with slice>=2), the first divide-mode edge SHALL set cnt=0, div_q=1.
REQ-018 Deassertion of i_clk_en[c] mid-period SHALL enter bypass on the next edge; the partial period is abandoned.
REQ-019 Ratio slice 0 or 1 SHALL be treated as bypass; no divide by zero, no stuck output.
REQ-020 Channels SHALL be fully independent; no channel's enable or ratio affects another.

Reset
REQ-021 While i_rst=1 at a rising edge: all cnt=0, div_q=0, R_act=0, o_tick=0; every o_div_clk follows i_ref_clk (bypass).
REQ-022 Reset asserted mid-period SHALL abort the period; after i_rst falls, an enabled channel with slice>=2 SHALL load R_act on the first edge and begin divide mode on the following edge per REQ-017.
REQ-023 No output SHALL depend on i_rst asynchronously.

Configuration
REQ-024 Macro CLK_DIV_MULTI_TICK_EN: when defined, o_tick exists and o_tick[c]=1 for exactly one ref cycle, registered, on each edge that sets cnt=0 in divide mode (including REQ-017 start), and is 0 in bypass and reset; when undefined, the o_tick port and its logic are omitted and the remaining behaviour is unchanged.

Verification
REQ-025 Ref period 16 ns, i_rst=1 for 3 cycles, then 0, ch0 en=1, ratio 4 -> o_div_clk[0] period 64 ns, 32 ns high/32 ns low, first rising edge 2 ref edges after reset release.
REQ-026 ch0 ratio 5, ch1 ratio 2 -> ch0 high 48 ns/low 32 ns (80 ns period); ch1 period 32 ns at 50% duty; no interaction.
REQ-027 ch0 ratio 4, change to 6 at cnt=1 -> current period completes at 64 ns; next period 96 ns.
REQ-028 ratio 0, ratio 1, or en=0 -> o_div_clk equals i_ref_clk; cnt stays 0; o_tick stays 0.
REQ-029 i_rst=1 asserted at cnt=2, ratio 6 -> next edge cnt=0, div_q=0, bypass output; divide mode restarts cleanly after release.
REQ-030 With CLK_DIV_MULTI_TICK_EN, ratio 3 -> o_tick[0] single 16 ns pulse every 48 ns, coincident with each o_div_clk[0] rising edge.

Source files
------------

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//   N_CH independent integer clock dividers running off a single reference
//   clock. Each channel divides i_ref_clk by a per-channel ratio R:
//     - R >= 2 and channel enabled : o_div_clk is a registered divided clock,
//       high for ceil(R/2) ref cycles and low for floor(R/2) ref cycles.
//     - R <= 1 or channel disabled : bypass, o_div_clk follows i_ref_clk.
//   A new ratio is adopted only at a period boundary, so a ratio change never
//   produces a runt or stretched period.
//
//   Optional feature macro: CLK_DIV_MULTI_TICK_EN
//     When defined, adds o_tick: a registered one-ref-cycle pulse on every
//     divided-clock period start. When undefined, o_tick and its logic are
//     absent and all other behaviour is identical.
// ---------------------------------------------------------------------------
module clk_div_multi #(
    parameter int N_CH        = 2,
    parameter int RATIO_WIDTH = 4
) (
    input  logic                        i_ref_clk,
    input  logic                        i_rst,
    input  logic [N_CH-1:0]             i_clk_en,
    input  logic [N_CH*RATIO_WIDTH-1:0] i_div_ratio,
    output logic [N_CH-1:0]             o_div_clk
`ifdef CLK_DIV_MULTI_TICK_EN
    ,
    output logic [N_CH-1:0]             o_tick
`endif
);

    localparam logic [RATIO_WIDTH-1:0] ONE_R = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH:0]   ONE_H = (RATIO_WIDTH + 1)'(1);

    // Per-channel sequencing state. ST_IDLE means no divided period is in
    // progress (bypass, or armed with a valid ratio but not yet started);
    // ST_RUN means the counter is walking through a period.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                 state_q [N_CH];
    state_e                 state_d [N_CH];
    logic [RATIO_WIDTH-1:0] r_act_q [N_CH];
    logic [RATIO_WIDTH-1:0] r_act_d [N_CH];
    logic [RATIO_WIDTH-1:0] cnt_q   [N_CH];
    logic [RATIO_WIDTH-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]        div_q;
    logic [N_CH-1:0]        div_d;
    logic [N_CH-1:0]        bypass;
`ifdef CLK_DIV_MULTI_TICK_EN
    logic [N_CH-1:0]        tick_q;
    logic [N_CH-1:0]        tick_d;
`endif

    // Bypass decode: a channel divides only when enabled with an active ratio of 2 or more.
    always_comb begin
        bypass = '0;
        for (int c = 0; c < N_CH; c++) begin
            bypass[c] = !i_clk_en[c] || (r_act_q[c] <= ONE_R);
        end
    end

    // Next-state logic for every channel: bypass load, period start, count and wrap.
    always_comb begin
        logic [RATIO_WIDTH-1:0] slice;
        logic [RATIO_WIDTH-1:0] cnt_inc;
        logic [RATIO_WIDTH:0]   half;
        // NOTE: every output of a combinational block gets a default before any
        // branch; a path that leaves one unassigned would infer a latch.
        slice   = '0;
        cnt_inc = '0;
        half    = '0;
        div_d   = div_q;
`ifdef CLK_DIV_MULTI_TICK_EN
        tick_d  = '0;
`endif
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            r_act_d[c] = r_act_q[c];
            cnt_d[c]   = cnt_q[c];

            slice   = i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH];
            cnt_inc = cnt_q[c] + ONE_R;
            // High phase length ceil(R/2), computed one bit wider so R = max does not overflow.
            half    = ({1'b0, r_act_q[c]} + ONE_H) >> 1;

            if (bypass[c]) begin
                // Bypass: keep the counter parked and track the ratio input every cycle.
                state_d[c] = ST_IDLE;
                r_act_d[c] = slice;
                cnt_d[c]   = '0;
                div_d[c]   = 1'b0;
            end else if (state_q[c] == ST_IDLE) begin
                // First divide-mode edge: open a period with the already-loaded ratio.
                state_d[c] = ST_RUN;
                cnt_d[c]   = '0;
                div_d[c]   = 1'b1;
`ifdef CLK_DIV_MULTI_TICK_EN
                tick_d[c]  = 1'b1;
`endif
            end else if (cnt_q[c] == (r_act_q[c] - ONE_R)) begin
                // Period boundary: the only point where a running channel adopts a new ratio.
                r_act_d[c] = slice;
                cnt_d[c]   = '0;
                if (slice > ONE_R) begin
                    div_d[c]  = 1'b1;
`ifdef CLK_DIV_MULTI_TICK_EN
                    tick_d[c] = 1'b1;
`endif
                end else begin
                    // New ratio means bypass: settle straight into the bypass state.
                    state_d[c] = ST_IDLE;
                    div_d[c]   = 1'b0;
                end
            end else begin
                cnt_d[c] = cnt_inc;
                div_d[c] = ({1'b0, cnt_inc} < half);
            end
        end
    end

    // State registers with synchronous reset; reset parks every channel in bypass.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= ST_IDLE;
                r_act_q[c] <= '0;
                cnt_q[c]   <= '0;
            end
            div_q  <= '0;
`ifdef CLK_DIV_MULTI_TICK_EN
            tick_q <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples its pre-edge inputs regardless of statement order.
            state_q <= state_d;
            r_act_q <= r_act_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
`ifdef CLK_DIV_MULTI_TICK_EN
            tick_q  <= tick_d;
`endif
        end
    end

    // Output mux: bypass passes the reference clock through, otherwise the registered divider.
    always_comb begin
        o_div_clk = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_div_clk[c] = bypass[c] ? i_ref_clk : div_q[c];
        end
    end

`ifdef CLK_DIV_MULTI_TICK_EN
    assign o_tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
//   Directed bench for clk_div_multi (N_CH=2, RATIO_WIDTH=4), 16 ns reference.
//   Outputs are sampled 1 ns after each rising edge (ref high) and, for the
//   bypass checks, 1 ns after a falling edge (ref low). o_tick is checked
//   when CLK_DIV_MULTI_TICK_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic [7:0] ratio;
    logic [1:0] div_clk;
`ifdef CLK_DIV_MULTI_TICK_EN
    logic [1:0] tick;
`endif

    int checks   = 0;
    int failures = 0;

    always #8 clk = ~clk;

    clk_div_multi #(
        .N_CH        (2),
        .RATIO_WIDTH (4)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .o_div_clk   (div_clk)
`ifdef CLK_DIV_MULTI_TICK_EN
        ,
        .o_tick      (tick)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample both outputs while the reference clock is low.
    task automatic lo_chk(input string tag, input logic [1:0] exp);
        @(negedge clk);
        #1;
        chk(tag, 32'(div_clk), 32'(exp));
    endtask

    // Run n ref edges; bit n-1-i of each vector is the expectation after edge i.
    task automatic run_seq(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] t0, input logic [31:0] t1, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_div0[%0d]", tag, i), 32'(div_clk[0]), 32'(d0[n-1-i]));
            chk($sformatf("%s_div1[%0d]", tag, i), 32'(div_clk[1]), 32'(d1[n-1-i]));
`ifdef CLK_DIV_MULTI_TICK_EN
            chk($sformatf("%s_tick0[%0d]", tag, i), 32'(tick[0]), 32'(t0[n-1-i]));
            chk($sformatf("%s_tick1[%0d]", tag, i), 32'(tick[1]), 32'(t1[n-1-i]));
`endif
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 2'b01;
        ratio = {4'd0, 4'd4};

        // Reset: three cycles, every channel follows the reference clock.
        step();
        chk("rst_hi", 32'(div_clk), 32'h3);
        chk("rst_cnt0", 32'(dut.cnt_q[0]), 32'h0);
`ifdef CLK_DIV_MULTI_TICK_EN
        chk("rst_tick", 32'(tick), 32'h0);
`endif
        lo_chk("rst_lo", 2'b00);
        step();
        step();
        rst = 1'b0;

        // Ratio 4: load edge, then 2 high / 2 low; ch1 disabled follows ref.
        run_seq("r4", 32'b011001100, 32'b111111111, 32'b010001000, 32'b0, 9);
        lo_chk("r4_lo", 2'b00);

        // ch0 ratio 5 (3 high / 2 low), ch1 enabled at ratio 2.
        en    = 2'b11;
        ratio = {4'd2, 4'd5};
        run_seq("r5r2", 32'b1110011100, 32'b0101010101, 32'b1000010000, 32'b0101010101, 10);

        // ch0 ratio 4, changed to 6 at cnt=1: 64 ns period completes, then 96 ns.
        ratio = {4'd2, 4'd4};
        run_seq("r4b", 32'b11, 32'b01, 32'b10, 32'b01, 2);
        ratio = {4'd2, 4'd6};
        run_seq("r6", 32'b001110001, 32'b010101010, 32'b001000001, 32'b010101010, 9);

        // Reset asserted mid-period at cnt=2 with ratio 6.
        run_seq("pre_rst", 32'b11, 32'b10, 32'b00, 32'b10, 2);
        chk("pre_rst_cnt0", 32'(dut.cnt_q[0]), 32'h2);
        rst = 1'b1;
        step();
        chk("mid_rst_hi", 32'(div_clk), 32'h3);
        chk("mid_rst_cnt0", 32'(dut.cnt_q[0]), 32'h0);
        chk("mid_rst_cnt1", 32'(dut.cnt_q[1]), 32'h0);
        chk("mid_rst_divq", 32'(dut.div_q), 32'h0);
`ifdef CLK_DIV_MULTI_TICK_EN
        chk("mid_rst_tick", 32'(tick), 32'h0);
`endif
        rst = 1'b0;
        lo_chk("post_rst_lo", 2'b00);
        run_seq("rst_rec", 32'b01110, 32'b01010, 32'b01000, 32'b01010, 5);

        // ch0 ratio 1 (adopted at the period boundary), ch1 disabled mid-period.
        en    = 2'b01;
        ratio = {4'd2, 4'd1};
        run_seq("r1", 32'b001111, 32'b111111, 32'b0, 32'b0, 6);
        chk("r1_cnt0", 32'(dut.cnt_q[0]), 32'h0);
        chk("r1_cnt1", 32'(dut.cnt_q[1]), 32'h0);
        lo_chk("r1_lo", 2'b00);

        // ch0 ratio 0: bypass, no stuck output.
        ratio = {4'd2, 4'd0};
        run_seq("r0", 32'b11, 32'b11, 32'b0, 32'b0, 2);
        chk("r0_cnt0", 32'(dut.cnt_q[0]), 32'h0);
        lo_chk("r0_lo", 2'b00);

        // ch0 ratio 3: 2 high / 1 low, tick coincident with every rising edge.
        ratio = {4'd2, 4'd3};
        run_seq("r3", 32'b01101101, 32'b11111111, 32'b01001001, 32'b0, 8);

        // Enable dropped mid-period: output follows ref at once, state clears next edge.
        en = 2'b00;
        lo_chk("dis_lo", 2'b00);
        step();
        chk("dis_hi", 32'(div_clk), 32'h3);
        chk("dis_cnt0", 32'(dut.cnt_q[0]), 32'h0);
        en = 2'b01;
        run_seq("reen", 32'b1, 32'b1, 32'b1, 32'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
